mem_arbiter_68k: RTL and testbench

MEM_ARBITER_68K -- requirements
Module: mem_arbiter_68k

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_wdog.sv | 27 ++
 rtl/mem_arbiter_68k.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter_68k.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the 68000 / SPI-loader memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W     = 23;
  localparam int DEF_STARVE_MAX = 15;
  localparam int DEF_TIMEOUT    = 255;

  typedef enum logic [1:0] {
    IDLE,
    CPU_ACC,
    SPI_ACC,
    CPU_HOLD
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_SPI
  } owner_t;

endpackage

// File: rtl/mem_arb_wdog.sv
// Access watchdog: flags an access whose mem_ack has not arrived within TIMEOUT cycles.
module mem_arb_wdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  input  logic mem_ack,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Counter restarts every time the strobe goes high, so each access gets a fresh budget.
  always_ff @(posedge clk) begin
    if (reset || !busy)  cnt <= '0;
    else if (cnt != LAST) cnt <= cnt + 1'b1;
  end

  assign expired = busy && !mem_ack && (cnt == LAST);

endmodule

// File: rtl/mem_arbiter_68k.sv
// Arbitrates a 68000 bus and an SPI loader onto one SDRAM controller port.
// Optional access watchdog / bus-error path enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter_68k
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_as_n,
  input  logic [1:0]        cpu_ds_n,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_dtack_n,
  output logic              cpu_berr_n,
  input  logic              spi_req,
  input  logic              spi_we,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [15:0]       spi_wdata,
  output logic [15:0]       spi_rdata,
  output logic              spi_ack,
  output logic              mem_as_n,
  output logic [1:0]        mem_ds_n,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] S_MAX = SW'(STARVE_MAX);

  if (STARVE_MAX < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("mem_arbiter_68k: STARVE_MAX and TIMEOUT must be >= 1");
  end

  state_t        state;
  owner_t        win;
  logic [SW-1:0] starve;
  logic          cpu_pend;
  logic          spi_pend;

  assign cpu_pend = ~cpu_as_n;
  // The loader only sees spi_ack as the edge that would re-grant it passes, so its
  // request is masked during the ack cycle to avoid a phantom second access.
  assign spi_pend = spi_req & ~spi_ack;

  always_comb begin
    win = OWN_NONE;
    if (state == IDLE) begin
      if (cpu_pend && !(spi_pend && starve == S_MAX)) win = OWN_CPU;
      else if (spi_pend)                              win = OWN_SPI;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                         starve <= '0;
    else if (win == OWN_SPI)                           starve <= '0;
    else if (spi_pend && state != SPI_ACC && starve != S_MAX) starve <= starve + 1'b1;
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic timeout;

  mem_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .busy    (~mem_as_n),
    .mem_ack (mem_ack),
    .expired (timeout)
  );
`else
  assign cpu_berr_n = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mem_as_n    <= 1'b1;
      mem_ds_n    <= 2'b11;
      mem_rw      <= 1'b1;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_rdata   <= '0;
      cpu_dtack_n <= 1'b1;
      spi_rdata   <= '0;
      spi_ack     <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cpu_berr_n  <= 1'b1;
`endif
    end else begin
      spi_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (win == OWN_CPU) begin
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            mem_rw    <= cpu_rw;
            mem_ds_n  <= cpu_ds_n;
            mem_as_n  <= 1'b0;
            state     <= CPU_ACC;
          end else if (win == OWN_SPI) begin
            mem_addr  <= spi_addr;
            mem_wdata <= spi_wdata;
            mem_rw    <= ~spi_we;
            mem_ds_n  <= 2'b00;
            mem_as_n  <= 1'b0;
            state     <= SPI_ACC;
          end
        end
        CPU_ACC: begin
          if (mem_ack) begin
            cpu_rdata   <= mem_rdata;
            cpu_dtack_n <= 1'b0;
            mem_as_n    <= 1'b1;
            mem_ds_n    <= 2'b11;
            state       <= CPU_HOLD;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (timeout) begin
            cpu_berr_n <= 1'b0;
            mem_as_n   <= 1'b1;
            mem_ds_n   <= 2'b11;
            state      <= CPU_HOLD;
          end
`endif
        end
        SPI_ACC: begin
          if (mem_ack) begin
            spi_rdata <= mem_rdata;
            spi_ack   <= 1'b1;
            mem_as_n  <= 1'b1;
            mem_ds_n  <= 2'b11;
            state     <= IDLE;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (timeout) begin
            spi_rdata <= 16'hFFFF;
            spi_ack   <= 1'b1;
            mem_as_n  <= 1'b1;
            mem_ds_n  <= 2'b11;
            state     <= IDLE;
          end
`endif
        end
        CPU_HOLD: begin
          // Termination stays asserted until the 68000 ends its bus cycle.
          if (cpu_as_n) begin
            cpu_dtack_n <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
            cpu_berr_n  <= 1'b1;
`endif
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_68k.sv
// Scoreboard bench for mem_arbiter_68k; watchdog cases run when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter_68k;

  localparam int AW = 23;

  logic          clk, reset;
  logic          cpu_as_n, cpu_rw, cpu_dtack_n, cpu_berr_n;
  logic [1:0]    cpu_ds_n;
  logic [AW-1:0] cpu_addr;
  logic [15:0]   cpu_wdata, cpu_rdata;
  logic          spi_req, spi_we, spi_ack;
  logic [AW-1:0] spi_addr;
  logic [15:0]   spi_wdata, spi_rdata;
  logic          mem_as_n, mem_rw, mem_ack;
  logic [1:0]    mem_ds_n;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata, mem_rdata;

  mem_arbiter_68k dut (
    .clk(clk), .reset(reset),
    .cpu_as_n(cpu_as_n), .cpu_ds_n(cpu_ds_n), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_dtack_n(cpu_dtack_n), .cpu_berr_n(cpu_berr_n),
    .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_rdata(spi_rdata), .spi_ack(spi_ack),
    .mem_as_n(mem_as_n), .mem_ds_n(mem_ds_n), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rw;
    logic [1:0]    ds;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic [15:0]   rdata;
  } mtx_t;

  mtx_t exp_q[$];
  mtx_t cur;
  int   n_chk = 0, n_err = 0;
  int   lat;
  bit   ack_en = 1'b1;
  localparam int ACK_DLY = 3;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic rw, input logic [1:0] ds, input logic [AW-1:0] a,
                      input logic [15:0] wd, input logic [15:0] rd);
    mtx_t t;
    t.rw = rw; t.ds = ds; t.addr = a; t.wdata = wd; t.rdata = rd;
    exp_q.push_back(t);
  endtask

  // SDRAM controller model: checks each new access against the queue, acks after ACK_DLY cycles.
  initial begin
    mem_ack = 1'b0; mem_rdata = '0; lat = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_as_n) lat = 0;
      else begin
        lat++;
        if (lat == 1) begin
          chk("access_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            chk("mem_addr", mem_addr, cur.addr);
            chk("mem_rw", mem_rw, cur.rw);
            chk("mem_ds_n", mem_ds_n, cur.ds);
            chk("mem_wdata", mem_wdata, cur.wdata);
          end
        end
        if (ack_en && lat == ACK_DLY) begin
          chk("mem_addr_held", mem_addr, cur.addr);
          mem_rdata = cur.rdata;
          mem_ack   = 1'b1;
        end
      end
    end
  end

  task automatic reset_chk(input string tag);
    chk({tag, "_mem_as_n"}, mem_as_n, 1);
    chk({tag, "_mem_ds_n"}, mem_ds_n, 2'b11);
    chk({tag, "_mem_rw"}, mem_rw, 1);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
    chk({tag, "_dtack_n"}, cpu_dtack_n, 1);
    chk({tag, "_berr_n"}, cpu_berr_n, 1);
    chk({tag, "_spi_rdata"}, spi_rdata, 0);
    chk({tag, "_spi_ack"}, spi_ack, 0);
  endtask

  // Starts at a negedge, returns at the negedge after dtack has been released.
  task automatic cpu_access(input logic rw, input logic [1:0] ds, input logic [AW-1:0] a,
                            input logic [15:0] wd, input logic [15:0] exp_rd, input int hold,
                            input string tag, output int n);
    cpu_as_n = 1'b0; cpu_ds_n = ds; cpu_rw = rw; cpu_addr = a; cpu_wdata = wd; n = 0;
    do begin @(negedge clk); n++; end while (cpu_dtack_n && n < 400);
    chk({tag, "_dtack"}, cpu_dtack_n, 0);
    chk({tag, "_rdata"}, cpu_rdata, exp_rd);
    repeat (hold) begin
      @(negedge clk);
      chk({tag, "_dtack_hold"}, cpu_dtack_n, 0);
    end
    cpu_as_n = 1'b1; cpu_ds_n = 2'b11;
    @(negedge clk);
    chk({tag, "_dtack_rel"}, cpu_dtack_n, 1);
  endtask

  task automatic spi_access(input logic we, input logic [AW-1:0] a, input logic [15:0] wd,
                            input logic [15:0] exp_rd, input string tag, output int n);
    spi_req = 1'b1; spi_we = we; spi_addr = a; spi_wdata = wd; n = 0;
    do begin @(negedge clk); n++; end while (!spi_ack && n < 400);
    spi_req = 1'b0;
    chk({tag, "_ack"}, spi_ack, 1);
    chk({tag, "_rdata"}, spi_rdata, exp_rd);
    @(negedge clk);
    chk({tag, "_ack_pulse"}, spi_ack, 0);
  endtask

  int n, s_lat;

  initial begin
    reset = 1'b1;
    cpu_as_n = 1'b1; cpu_ds_n = 2'b11; cpu_rw = 1'b1; cpu_addr = '0; cpu_wdata = '0;
    spi_req = 1'b0; spi_we = 1'b0; spi_addr = '0; spi_wdata = '0;
    repeat (3) @(negedge clk);
    reset_chk("rst");
    reset = 1'b0;
    @(negedge clk);

    // CPU read: grant on first edge, ack 3 cycles later -> dtack seen on 4th negedge
    push(1'b1, 2'b00, 23'h000100, 16'h0000, 16'h4E71);
    cpu_access(1'b1, 2'b00, 23'h000100, 16'h0000, 16'h4E71, 2, "cpu_rd", n);
    chk("cpu_rd_lat", n, 4);

    // CPU upper-byte write
    push(1'b0, 2'b01, 23'h000200, 16'h1234, 16'h0BAD);
    cpu_access(1'b0, 2'b01, 23'h000200, 16'h1234, 16'h0BAD, 0, "cpu_wr", n);

    // SPI write then read: full-word strobes, rw = ~we
    push(1'b0, 2'b00, 23'h000010, 16'hBEEF, 16'h0000);
    spi_access(1'b1, 23'h000010, 16'hBEEF, 16'h0000, "spi_wr", n);
    chk("spi_wr_lat", n, 4);
    push(1'b1, 2'b00, 23'h000020, 16'h0000, 16'hA5A5);
    spi_access(1'b0, 23'h000020, 16'h0000, 16'hA5A5, "spi_rd", n);

    // Contention: CPU cycles take 5 clocks (grant, 3-cycle ack, release), so CPU wins
    // at edges 0, 5, 10 while the starve count climbs; at edge 15 it is 15 and SPI wins,
    // acks at edge 18 (seen on negedge 19). The 4th CPU cycle waits behind it.
    for (int i = 0; i < 3; i++) push(1'b1, 2'b00, 23'h300 + 23'(2 * i), 16'h0, 16'hC000 + 16'(i));
    push(1'b0, 2'b00, 23'h000040, 16'h5555, 16'h5A5A);
    push(1'b1, 2'b00, 23'h000306, 16'h0, 16'hC003);
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          int m;
          cpu_access(1'b1, 2'b00, 23'h300 + 23'(2 * i), 16'h0, 16'hC000 + 16'(i), 0, "starve_cpu", m);
        end
      end
      spi_access(1'b1, 23'h000040, 16'h5555, 16'h5A5A, "starve_spi", s_lat);
    join
    chk("starve_spi_lat", s_lat, 19);

    // Reset two cycles into a CPU access: abort with no termination
    ack_en = 1'b0;
    push(1'b1, 2'b00, 23'h000400, 16'h0, 16'h0);
    cpu_as_n = 1'b0; cpu_ds_n = 2'b00; cpu_rw = 1'b1; cpu_addr = 23'h000400;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset_chk("rst_mid");
    cpu_as_n = 1'b1; cpu_ds_n = 2'b11;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_no_dtack", cpu_dtack_n, 1);
    chk("rst_mid_idle", mem_as_n, 1);

`ifdef MEM_ARB_TIMEOUT_EN
    // No mem_ack: strobe is low for 255 cycles, bus error seen on the 256th negedge
    push(1'b1, 2'b00, 23'h000500, 16'h0, 16'h0);
    cpu_as_n = 1'b0; cpu_ds_n = 2'b00; cpu_rw = 1'b1; cpu_addr = 23'h000500; n = 0;
    do begin @(negedge clk); n++; end while (cpu_berr_n && n < 400);
    chk("to_cpu_berr", cpu_berr_n, 0);
    chk("to_cpu_lat", n, 256);
    chk("to_cpu_as_n", mem_as_n, 1);
    chk("to_cpu_no_dtack", cpu_dtack_n, 1);
    cpu_as_n = 1'b1; cpu_ds_n = 2'b11;
    @(negedge clk);
    chk("to_cpu_berr_rel", cpu_berr_n, 1);

    push(1'b1, 2'b00, 23'h000600, 16'h0, 16'h0);
    spi_access(1'b0, 23'h000600, 16'h0, 16'hFFFF, "to_spi", n);
    chk("to_spi_lat", n, 256);
`endif

    ack_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
